bit_serial_subtractor: RTL
==========================

Name: bit_serial_subtractor

Overview:
- Sequential counterpart to the team's dataflow full adder. It computes diff = a - b - borrow_in one bit per clock, LSB first.
- The datapath is a single full-subtractor cell plus a borrow flip-flop.
- Used as a small-area arithmetic unit, and as the inverse-operation checker for the adder blocks.
- A start/busy/done handshake frames each operation.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- borrow_in  input  1  initial borrow; captured on the accepted start.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; the result is valid.
- diff  output  WIDTH  result register.
- borrow_out  output  1  final borrow (unsigned underflow).

Behaviour:
- Reset: on rst=1 at a clock edge, the following are cleared to 0: state=IDLE, busy, done, diff, borrow_out, the count, the operand shift registers and the borrow flip-flop. Reset mid-operation aborts it and no done is produced.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: if start=1, the block captures:
  - a into sa and b into sb;
  - borrow_in into the borrow flop;
  - count=0.
  It then moves to SHIFT and busy=1.
- Outputs across operations: diff and borrow_out hold their previous result until the next operation completes.
- SHIFT: on each edge the full-subtractor cell evaluates:
  - d = sa[0] ^ sb[0] ^ bf
  - bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf)
- SHIFT update on the same edge:
  - d shifts into the MSB of the result shift register rs (right shift);
  - sa and sb shift right;
  - bf <= bo;
  - count increments.
- Leaving SHIFT: on the edge where count = WIDTH-1, the block loads diff <= {d, rs[WIDTH-1:1]} and borrow_out <= bo. It goes to DONE with busy=0 and done=1.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally with done=0.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH, so the total is WIDTH+1 cycles from start to done.
- Throughput: start may be reasserted in the cycle after done (IDLE). A start held high continuously produces back-to-back operations every WIDTH+2 cycles.
- Start while busy or while in DONE: ignored; operands are not re-captured.
- Arithmetic: modulo 2^WIDTH. borrow_out=1 iff a < b + borrow_in, treating the operands as unsigned.
- Input changes on a/b/borrow_in after capture have no effect.
- Counter width: $clog2(WIDTH). Counter wrap-around is never reached, because the block leaves SHIFT at WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds an output port ovf (1 bit), reset to 0.
  - ovf is loaded together with diff: ovf = borrow into the MSB XOR borrow out of the MSB. This is the two's-complement signed overflow of a - b - borrow_in.
  - The block also keeps a 1-bit register holding bf before the MSB step.
- Undefined: no ovf port and no extra register; all other behaviour is identical.

Decomposition:
- Shared package sub_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default width constant SUB_DEF_WIDTH=8.
- One sub-module is natural: full_subtractor. It is purely combinational, with ports a, b, b_in, diff, b_out, and is the bit-cell instantiated inside the SHIFT datapath.
- The top level keeps the FSM, the counter and the shift registers.

Test Plan:
- Basic: WIDTH=8, a=100, b=37, borrow_in=0, start pulsed -> done exactly 9 cycles after start, diff=63, borrow_out=0, busy high for 8 cycles.
- Underflow: a=5, b=9, borrow_in=0 -> diff=252 (0xFC), borrow_out=1. Separately, a=0, b=0, borrow_in=1 -> diff=0xFF, borrow_out=1.
- Handshake: pulse start again at cycle 3 of a busy operation with different operands -> ignored; the first result is unchanged and there is only one done pulse. Holding start high continuously -> done every 10 cycles.
- Reset mid-op: assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0, borrow_out=0, state IDLE. A new start afterwards completes correctly.
- Exhaustive self-check with WIDTH=4:
  - Coverage: all 512 combinations of a, b and borrow_in.
  - Check: diff and borrow_out compared against a behavioural a-b-borrow_in, and diff+b+borrow_in == a mod 16 cross-checked.
- With SERIAL_SUB_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x10, b=0x01 -> diff=0x0F, ovf=0.

Source files
------------

// File: rtl/sub_pkg.sv
// ============================================================================
// Module   : sub_pkg
// Brief    : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sub_pkg;

    localparam int SUB_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : Single-bit combinational full subtractor (a - b - b_in).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

`default_nettype wire

// File: rtl/bit_serial_subtractor.sv
// ============================================================================
// Module   : bit_serial_subtractor
// Brief    : LSB-first serial a - b - borrow_in with start/busy/done framing.
//            Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, diff_q;
    logic [WIDTH-2:0] rs_q;
    logic             bf_q, bout_q;
    logic [CW-1:0]    cnt_q;
    logic             w_d, w_bo, w_last;
    logic [WIDTH-1:0] w_rs_next;

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .b_in (bf_q),
        .diff (w_d),
        .b_out(w_bo)
    );

    // Only WIDTH-1 result bits are stored; the final bit joins them on the last step.
    assign w_rs_next = {w_d, rs_q};
    assign w_last    = (cnt_q == C_LAST);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last) state_d = ST_DONE;
            end
            ST_DONE:  begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            rs_q    <= '0;
            diff_q  <= '0;
            bf_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                sa_q  <= a;
                sb_q  <= b;
                bf_q  <= borrow_in;
                cnt_q <= '0;
            end else if (state_q == ST_SHIFT) begin
                sa_q  <= sa_q >> 1;
                sb_q  <= sb_q >> 1;
                rs_q  <= w_rs_next[WIDTH-1:1];
                bf_q  <= w_bo;
                cnt_q <= cnt_q + CW'(1);
                if (w_last) begin
                    diff_q <= w_rs_next;
                    bout_q <= w_bo;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // On the MSB step bf_q is the borrow into the MSB, w_bo the borrow out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_SHIFT && w_last) begin
            ovf_q <= bf_q ^ w_bo;
        end
    end

    assign ovf = ovf_q;
`endif

    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

`default_nettype wire
